// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - data-bus request/response bundle between the memory stage and the bus
interface mem_access_ctrl_if;

   typedef struct packed {
      logic        valid;
      logic [63:0] addr;
      logic [2:0]  size;
      logic [7:0]  strobe;
      logic [63:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [63:0] data;
   } dbus_resp_t;

   dbus_req_t  dreq;
   dbus_resp_t dresp;

   modport master (output dreq, input dresp);
   modport slave  (input dreq, output dresp);

endinterface

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - sequences one memory-stage load/store over the data bus with a watchdog
module mem_access_ctrl #(
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req_valid,
   input  logic                 req_write,
   input  logic [63:0]          req_addr,
   input  logic [63:0]          req_wdata,
   input  logic [7:0]           req_strobe,
   input  logic                 flush,
   mem_access_ctrl_if.master    bus,
   output logic                 stall,
   output logic                 resp_valid,
   output logic [63:0]          resp_rdata,
   output logic                 resp_err
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] WAIT = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   localparam logic [2:0]  MSIZE8    = 3'd3;
   localparam logic        wdEnabled = (TIMEOUT != 0);
   localparam logic [31:0] wdLimit   = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

   logic [1:0]  state;
   logic [1:0]  stateNext;
   logic        holdWrite;
   logic [63:0] holdAddr;
   logic [63:0] holdWdata;
   logic [7:0]  holdStrobe;
   logic [31:0] wdCount;

   logic accept;
   logic busActive;
   logic timedOut;
   logic finishOk;
   logic finishErr;

   assign accept    = (state == IDLE) & req_valid & ~flush;
   assign busActive = (state == REQ) | (state == WAIT);
   assign timedOut  = wdEnabled & (wdCount == wdLimit);

   // data_ok always beats the watchdog; a flush only drops a request the bus has not taken yet
   always_comb begin
      stateNext = state;
      finishOk  = 1'b0;
      finishErr = 1'b0;
      case (state)
         IDLE: begin
            if (accept) stateNext = REQ;
         end
         REQ: begin
            if (bus.dresp.addr_ok & bus.dresp.data_ok) begin
               finishOk  = 1'b1;
               stateNext = DONE;
            end else if (!bus.dresp.addr_ok & flush) begin
               stateNext = IDLE;
            end else if (timedOut) begin
               finishErr = 1'b1;
               stateNext = DONE;
            end else if (bus.dresp.addr_ok) begin
               stateNext = WAIT;
            end
         end
         WAIT: begin
            if (bus.dresp.data_ok) begin
               finishOk  = 1'b1;
               stateNext = DONE;
            end else if (timedOut) begin
               finishErr = 1'b1;
               stateNext = DONE;
            end
         end
         DONE: stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         holdWrite  <= 1'b0;
         holdAddr   <= 64'd0;
         holdWdata  <= 64'd0;
         holdStrobe <= 8'd0;
         wdCount    <= 32'd0;
         resp_rdata <= 64'd0;
         resp_err   <= 1'b0;
      end else begin
         state <= stateNext;
         if (accept) begin
            holdWrite  <= req_write;
            holdAddr   <= req_addr;
            holdWdata  <= req_wdata;
            holdStrobe <= req_strobe;
            wdCount    <= 32'd0;
         end else if (busActive && (wdCount != 32'hFFFF_FFFF)) begin
            wdCount <= wdCount + 32'd1;
         end
         if (finishOk) begin
            resp_rdata <= holdWrite ? 64'd0 : bus.dresp.data;
            resp_err   <= 1'b0;
         end else if (finishErr) begin
            resp_rdata <= 64'd0;
            resp_err   <= 1'b1;
         end
      end
   end

   // reset gating keeps stall low while held in reset even if req_valid is high
   assign stall      = reset & (accept | busActive);
   assign resp_valid = (state == DONE);

   assign bus.dreq.valid  = busActive;
   assign bus.dreq.addr   = holdAddr;
   assign bus.dreq.size   = MSIZE8;
   assign bus.dreq.strobe = holdWrite ? holdStrobe : 8'd0;
   assign bus.dreq.data   = holdWdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench for mem_access_ctrl
module tb_mem_access_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        resetN;
   logic        reqValid;
   logic        reqValid0;
   logic        reqWrite;
   logic [63:0] reqAddr;
   logic [63:0] reqWdata;
   logic [7:0]  reqStrobe;
   logic        flush;

   logic        stall, respValid, respErr;
   logic [63:0] respRdata;
   logic        stall0, respValid0, respErr0;
   logic [63:0] respRdata0;

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic [63:0] rdata;
      logic        err;
   } exp_t;
   exp_t sbQ[$];

   mem_access_ctrl_if busA();
   mem_access_ctrl_if busB();

   assign busB.dresp = '0;

   mem_access_ctrl #(.TIMEOUT(8)) dut (
      .clk(clk), .reset(resetN), .req_valid(reqValid), .req_write(reqWrite),
      .req_addr(reqAddr), .req_wdata(reqWdata), .req_strobe(reqStrobe), .flush(flush),
      .bus(busA), .stall(stall), .resp_valid(respValid), .resp_rdata(respRdata), .resp_err(respErr)
   );

   mem_access_ctrl #(.TIMEOUT(0)) dut0 (
      .clk(clk), .reset(resetN), .req_valid(reqValid0), .req_write(reqWrite),
      .req_addr(reqAddr), .req_wdata(reqWdata), .req_strobe(reqStrobe), .flush(flush),
      .bus(busB), .stall(stall0), .resp_valid(respValid0), .resp_rdata(respRdata0), .resp_err(respErr0)
   );

   always @(negedge clk) begin
      exp_t e;
      if (resetN && respValid) begin
         checks++;
         if (sbQ.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected: resp_valid with rdata=%h err=%b, no completion expected", respRdata, respErr);
         end else begin
            e = sbQ.pop_front();
            if (respRdata !== e.rdata || respErr !== e.err) begin
               failures++;
               $display("FAIL sb_resp: got rdata=%h err=%b expected rdata=%h err=%b", respRdata, respErr, e.rdata, e.err);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      resetN = 1'b0; reqValid = 1'b1; reqValid0 = 1'b0; reqWrite = 1'b1;
      reqAddr = 64'h1234; reqWdata = 64'h5678; reqStrobe = 8'hFF; flush = 1'b0;
      busA.dresp = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({busA.dreq.valid, busA.dreq.addr, busA.dreq.strobe, busA.dreq.data, stall, respValid, respRdata, respErr} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got v=%b a=%h s=%h d=%h stall=%b rv=%b rd=%h re=%b expected all zero",
                  busA.dreq.valid, busA.dreq.addr, busA.dreq.strobe, busA.dreq.data, stall, respValid, respRdata, respErr);
      end
      reqValid = 1'b0;
      resetN = 1'b1;
   endtask

   task automatic test_load();
      step();
      reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 64'h8000_1000;
      reqWdata = {$urandom, $urandom}; reqStrobe = 8'hA5;
      sbQ.push_back('{rdata: 64'hDEADBEEF_CAFEF00D, err: 1'b0});
      @(negedge clk);
      checks++;
      if ({stall, busA.dreq.valid} !== 2'b10) begin
         failures++; $display("FAIL load_c0: got stall=%b valid=%b expected stall=1 valid=0", stall, busA.dreq.valid);
      end
      step();
      reqValid = 1'b0;
      busA.dresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'hDEADBEEF_CAFEF00D};
      @(negedge clk);
      checks++;
      if ({busA.dreq.valid, busA.dreq.addr, busA.dreq.strobe, busA.dreq.size, stall} !== {1'b1, 64'h8000_1000, 8'h00, 3'd3, 1'b1}) begin
         failures++;
         $display("FAIL load_c1: got v=%b a=%h s=%h sz=%0d stall=%b expected v=1 a=80001000 s=00 sz=3 stall=1",
                  busA.dreq.valid, busA.dreq.addr, busA.dreq.strobe, busA.dreq.size, stall);
      end
      step();
      busA.dresp = '0;
      @(negedge clk);
      checks++;
      if ({respValid, stall} !== 2'b10) begin
         failures++; $display("FAIL load_c2: got resp_valid=%b stall=%b expected 1 0", respValid, stall);
      end
      step();
      @(negedge clk);
      checks++;
      if ({respValid, stall} !== 2'b00) begin
         failures++; $display("FAIL load_c3: got resp_valid=%b stall=%b expected 0 0", respValid, stall);
      end
   endtask

   task automatic test_store();
      step();
      reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 64'h8000_2008;
      reqWdata = 64'h1122334455667788; reqStrobe = 8'h0F;
      sbQ.push_back('{rdata: 64'd0, err: 1'b0});
      for (int k = 1; k <= 6; k++) begin
         step();
         reqValid = 1'($urandom_range(0, 1)); reqWrite = 1'($urandom_range(0, 1));
         reqAddr = {$urandom, $urandom}; reqWdata = {$urandom, $urandom}; reqStrobe = 8'($urandom);
         busA.dresp = '{addr_ok: (k == 3), data_ok: (k == 6), data: {$urandom, $urandom}};
         @(negedge clk);
         checks++;
         if ({busA.dreq.valid, busA.dreq.addr, busA.dreq.strobe, busA.dreq.data, stall} !==
             {1'b1, 64'h8000_2008, 8'h0F, 64'h1122334455667788, 1'b1}) begin
            failures++;
            $display("FAIL store_hold_c%0d: got v=%b a=%h s=%h d=%h stall=%b expected v=1 a=80002008 s=0f d=1122334455667788 stall=1",
                     k, busA.dreq.valid, busA.dreq.addr, busA.dreq.strobe, busA.dreq.data, stall);
         end
      end
      step();
      reqValid = 1'b0; busA.dresp = '0;
      @(negedge clk);
      checks++;
      if ({respValid, stall, busA.dreq.valid} !== 3'b100) begin
         failures++; $display("FAIL store_c7: got rv=%b stall=%b v=%b expected 1 0 0", respValid, stall, busA.dreq.valid);
      end
   endtask

   task automatic test_flush_req();
      step();
      reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 64'h8000_3000;
      step();
      reqValid = 1'b0;
      step();
      flush = 1'b1;
      @(negedge clk);
      checks++;
      if ({busA.dreq.valid, stall} !== 2'b11) begin
         failures++; $display("FAIL flush_req_c2: got v=%b stall=%b expected 1 1", busA.dreq.valid, stall);
      end
      for (int k = 3; k <= 5; k++) begin
         step();
         flush = 1'b0;
         @(negedge clk);
         checks++;
         if ({busA.dreq.valid, stall, respValid} !== 3'b000) begin
            failures++;
            $display("FAIL flush_req_c%0d: got v=%b stall=%b rv=%b expected 0 0 0", k, busA.dreq.valid, stall, respValid);
         end
      end
   endtask

   task automatic test_flush_wait();
      step();
      reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 64'h8000_4000;
      sbQ.push_back('{rdata: 64'h0123456789ABCDEF, err: 1'b0});
      step();
      reqValid = 1'b0;
      busA.dresp = '{addr_ok: 1'b1, data_ok: 1'b0, data: 64'd0};
      step();
      busA.dresp = '0; flush = 1'b1;
      @(negedge clk);
      checks++;
      if ({busA.dreq.valid, stall} !== 2'b11) begin
         failures++; $display("FAIL flush_wait_c2: got v=%b stall=%b expected 1 1", busA.dreq.valid, stall);
      end
      step();
      busA.dresp = '{addr_ok: 1'b0, data_ok: 1'b1, data: 64'h0123456789ABCDEF};
      step();
      busA.dresp = '0;
      @(negedge clk);
      checks++;
      if ({respValid, stall} !== 2'b10) begin
         failures++; $display("FAIL flush_wait_c4: got rv=%b stall=%b expected 1 0", respValid, stall);
      end
      step();
      flush = 1'b0;
   endtask

   task automatic test_timeout();
      step();
      reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 64'h8000_7000;
      sbQ.push_back('{rdata: 64'd0, err: 1'b1});
      for (int k = 1; k <= 8; k++) begin
         step();
         reqValid = 1'b0;
         @(negedge clk);
         checks++;
         if ({busA.dreq.valid, stall, respValid} !== 3'b110) begin
            failures++;
            $display("FAIL timeout_c%0d: got v=%b stall=%b rv=%b expected 1 1 0", k, busA.dreq.valid, stall, respValid);
         end
      end
      step();
      @(negedge clk);
      checks++;
      if ({respValid, respErr, busA.dreq.valid} !== 3'b110) begin
         failures++; $display("FAIL timeout_c9: got rv=%b err=%b v=%b expected 1 1 0", respValid, respErr, busA.dreq.valid);
      end
      step();
      @(negedge clk);
      checks++;
      if ({respValid, busA.dreq.valid, stall} !== 3'b000) begin
         failures++; $display("FAIL timeout_c10: got rv=%b v=%b stall=%b expected 0 0 0", respValid, busA.dreq.valid, stall);
      end
      // data_ok landing on the final watchdog cycle completes normally
      step();
      reqValid = 1'b1; reqAddr = 64'h8000_7100;
      sbQ.push_back('{rdata: 64'hA5A5A5A5_5A5A5A5A, err: 1'b0});
      for (int k = 1; k <= 8; k++) begin
         step();
         reqValid = 1'b0;
         if (k == 8) busA.dresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'hA5A5A5A5_5A5A5A5A};
      end
      step();
      busA.dresp = '0;
      @(negedge clk);
      checks++;
      if ({respValid, respErr} !== 2'b10) begin
         failures++; $display("FAIL timeout_edge_data_wins: got rv=%b err=%b expected 1 0", respValid, respErr);
      end
   endtask

   task automatic test_no_watchdog();
      int hiCount = 0;
      int rvCount = 0;
      step();
      reqValid0 = 1'b1; reqWrite = 1'b0; reqAddr = 64'h8000_8000;
      step();
      reqValid0 = 1'b0;
      for (int k = 0; k < 120; k++) begin
         @(negedge clk);
         if (stall0) hiCount++;
         if (respValid0) rvCount++;
         step();
      end
      checks++;
      if (hiCount != 120) begin
         failures++; $display("FAIL no_watchdog_stall: got %0d stalled cycles expected 120", hiCount);
      end
      checks++;
      if (rvCount != 0) begin
         failures++; $display("FAIL no_watchdog_resp: got %0d completions expected 0", rvCount);
      end
   endtask

   task automatic test_reset_wait();
      step();
      reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 64'h8000_5000;
      reqWdata = 64'hCAFE; reqStrobe = 8'hFF;
      step();
      reqValid = 1'b0;
      busA.dresp = '{addr_ok: 1'b1, data_ok: 1'b0, data: 64'd0};
      step();
      busA.dresp = '0;
      @(negedge clk);
      checks++;
      if (busA.dreq.valid !== 1'b1) begin
         failures++; $display("FAIL reset_wait_pre: got v=%b expected 1", busA.dreq.valid);
      end
      #2;
      resetN = 1'b0;
      #1;
      checks++;
      if ({busA.dreq.valid, busA.dreq.addr, busA.dreq.strobe, busA.dreq.data, stall, respValid, respRdata, respErr, stall0} !== '0) begin
         failures++;
         $display("FAIL reset_wait_outputs: got v=%b a=%h s=%h d=%h stall=%b rv=%b rd=%h re=%b stall0=%b expected all zero",
                  busA.dreq.valid, busA.dreq.addr, busA.dreq.strobe, busA.dreq.data, stall, respValid, respRdata, respErr, stall0);
      end
      @(negedge clk);
      resetN = 1'b1;
      step();
      reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 64'h8000_6000;
      sbQ.push_back('{rdata: 64'hFEEDFACE_12345678, err: 1'b0});
      step();
      reqValid = 1'b0;
      busA.dresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'hFEEDFACE_12345678};
      step();
      busA.dresp = '0;
      @(negedge clk);
      checks++;
      if ({respValid, respErr} !== 2'b10) begin
         failures++; $display("FAIL reset_fresh_load: got rv=%b err=%b expected 1 0", respValid, respErr);
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] d;
      logic [63:0] a;
      for (int k = 0; k < 12; k++) begin
         step();
         d = 64'hB2B0_0000_0000_0000 | 64'(k / 3);
         a = 64'h8000_9000 + 64'(8 * (k / 3));
         reqValid = 1'b1; reqWrite = 1'b0; reqAddr = a;
         if (k % 3 == 0) sbQ.push_back('{rdata: d, err: 1'b0});
         if (k % 3 == 1) busA.dresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: d};
         else busA.dresp = '0;
         @(negedge clk);
         checks++;
         if ({busA.dreq.valid, respValid, stall} !== {(k % 3 == 1), (k % 3 == 2), (k % 3 != 2)} ||
             ((k % 3 == 1) && busA.dreq.addr !== a)) begin
            failures++;
            $display("FAIL b2b_c%0d: got v=%b rv=%b stall=%b a=%h expected v=%b rv=%b stall=%b a=%h", k,
                     busA.dreq.valid, respValid, stall, busA.dreq.addr, (k % 3 == 1), (k % 3 == 2), (k % 3 != 2), a);
         end
      end
      step();
      reqValid = 1'b0; busA.dresp = '0;
      @(negedge clk);
      checks++;
      if ({busA.dreq.valid, respValid, stall} !== 3'b000) begin
         failures++; $display("FAIL b2b_end: got v=%b rv=%b stall=%b expected 0 0 0", busA.dreq.valid, respValid, stall);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_load();
      test_store();
      test_flush_req();
      test_flush_wait();
      test_timeout();
      test_no_watchdog();
      test_reset_wait();
      test_back_to_back();
      step();
      checks++;
      if (sbQ.size() != 0) begin
         failures++; $display("FAIL sb_drained: got %0d pending completions expected 0", sbQ.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequences a single memory-stage load or store over the data-bus handshake (`dbus_req_t`/`dbus_resp_t`) on behalf of the pipeline. It sits between the memory stage and the data bus. It holds the request stable until the bus accepts and answers it, stalls the pipeline meanwhile, and returns load data with a one-cycle completion pulse. A watchdog turns a hung bus into an error completion.

## Interface
- `TIMEOUT`, default 1024: cycles allowed in REQ+WAIT before error completion; 0 disables the watchdog.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `req_valid`  in  1  memory stage has a load or store to perform.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  64  byte address.
- `req_wdata`  in  64  store data.
- `req_strobe`  in  8  byte enables for stores; ignored for loads.
- `flush`  in  1  pipeline flush of the memory-stage instruction.
- `dreq`  out  dbus_req_t  bus request (`valid`, `addr`, `size`=MSIZE8, `strobe`, `data`).
- `dresp`  in  dbus_resp_t  bus response (`addr_ok`, `data_ok`, `data`).
- `stall`  out  1  freeze the pipeline at and before the memory stage.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  64  load data; valid when `resp_valid`=1.
- `resp_err`  out  1  completion was a watchdog timeout; valid when `resp_valid`=1.

## Operation
- States: IDLE, REQ, WAIT, DONE; 2-bit register.
- IDLE: if `req_valid` & !`flush`, latch addr/wdata/strobe/write into holding registers, clear counter, go to REQ.
- REQ: `dreq.valid`=1, fields from holding registers. For loads, `dreq.strobe`=0.
  - `addr_ok`&`data_ok` same cycle → capture `dresp.data`, go to DONE.
  - `addr_ok` only → go to WAIT.
  - `flush` with no `addr_ok` → drop the request, go to IDLE; no completion pulse.
- WAIT: `dreq.valid` stays 1 with fields unchanged until `data_ok`. Then capture data and go to DONE. `flush` is ignored here; the transaction drains to DONE.
- DONE: `resp_valid`=1 and `stall`=0 for exactly one cycle, then IDLE. The completion is still produced if `flush` is high.
- `stall` = (IDLE & `req_valid` & !`flush`) | REQ | WAIT.
- Stores: `resp_rdata`=0.
- Watchdog: the counter increments each cycle in REQ/WAIT and saturates. When it reaches TIMEOUT−1 without `data_ok`, the block goes to DONE with `resp_err`=1, `resp_rdata`=0 and `dreq.valid` low from the next cycle. `data_ok` in the same cycle as the timeout wins: normal completion, err=0.
- The holding registers are written only in IDLE. Changes to pipeline inputs during REQ/WAIT/DONE are ignored.

## Timing
- Reset, any state: next state IDLE. `dreq.valid`=0, `dreq.addr`=0, `dreq.strobe`=0, `dreq.data`=0, `stall`=0, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, counter=0.
- Reset mid-transaction abandons it; no completion is produced.
- Latency: request seen in cycle 0 (IDLE) → `dreq.valid` in cycle 1 → completion at least in cycle 2, when `addr_ok`&`data_ok` arrive in cycle 1.
- Each additional bus wait cycle adds one cycle.
- Back-to-back accesses: the earliest next accept is the cycle after DONE, so there is at least one IDLE cycle between transactions.
- `resp_rdata`/`resp_err` are registered and hold until the next capture.

## Test plan
- Load to 0x80001000, bus returns `addr_ok`&`data_ok` in cycle 1 with data 0xDEADBEEF_CAFEF00D → `resp_valid` in cycle 2, rdata matches, `stall` high cycles 0–1 only.
- Store of 0x1122334455667788 with strobe 0x0F. `addr_ok` in cycle 3, `data_ok` in cycle 6. `dreq` fields must be constant cycles 1–6 while `req_*` inputs toggle. `resp_valid` in cycle 7 with rdata=0.
- Flush in cycle 2 while in REQ with no `addr_ok` → IDLE in cycle 3, no `resp_valid`. Flush in WAIT → transaction completes normally.
- TIMEOUT=8 and the bus never answers → `resp_valid`&`resp_err` 8 cycles after entering REQ, then `dreq.valid`=0. TIMEOUT=0 → stall persists for 100+ cycles.
- Assert reset low in WAIT → all outputs immediately at reset values. After release, a fresh load completes correctly.
- `req_valid` held high continuously → transactions complete with exactly one IDLE cycle between each DONE and the next REQ.
